// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line requests to a 64-bit, 4-beat burst memory port.
// Reads collect matching beats into a line; writes stream the latched line out.
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [26:0]   line_q, line_d;
    logic [1:0]    beat_q, beat_d;
    logic [255:0]  wline_q, wline_d;
    logic [191:0]  rbuf_q, rbuf_d;
    logic [255:0]  rdata_q, rdata_d;
    logic          beat_hit;
    logic [63:0]   wbeat [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_wbeat
        assign wbeat[gi] = wline_q[64*gi +: 64];
    end

    // Only beats for the line we asked for count; anything else is dropped.
    assign beat_hit  = bmem_rvalid && (bmem_raddr[31:5] == line_q);
    assign dfp_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        beat_d     = beat_q;
        wline_d    = wline_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        dfp_resp   = 1'b0;
        bmem_addr  = 32'd0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = 64'd0;

        unique case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    line_d  = dfp_addr[31:5];
                    wline_d = dfp_wdata;
                    beat_d  = 2'd0;
                    state_d = WR_BURST;
                end else if (dfp_read) begin
                    line_d  = dfp_addr[31:5];
                    beat_d  = 2'd0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = {line_q, 5'b0};
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                bmem_addr = {line_q, 5'b0};
                if (beat_hit) begin
                    beat_d = beat_q + 2'd1;
                    // Beats 0..2 shift in from the top; beat 3 completes the line.
                    if (beat_q == 2'd3) begin
                        rdata_d = {bmem_rdata, rbuf_q};
                        state_d = RESP;
                    end else begin
                        rbuf_d = {bmem_rdata, rbuf_q[191:64]};
                    end
                end
            end
            WR_BURST: begin
                bmem_addr = {line_q, 5'b0};
                // bmem_ready gates only the first beat; the rest stream unconditionally.
                if (beat_q != 2'd0 || bmem_ready) begin
                    bmem_write = 1'b1;
                    bmem_wdata = wbeat[beat_q];
                    beat_d     = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized self-checking bench for cacheline_adapter; expected lines and write
// beats come from the request data itself, checked cycle by cycle.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Invariants that must hold on every cycle out of reset.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            total++;
            if ((bmem_read && bmem_write) || (!bmem_write && bmem_wdata !== 64'd0)) begin
                bad++;
                $display("FAIL invariant: read=%b write=%b wdata=%h, required read&write=0 and wdata=0 when write=0",
                         bmem_read, bmem_write, bmem_wdata);
            end
        end
    end

    task automatic run_read(input string name, input logic [31:0] addr, input logic [255:0] line,
                            input int rdy_dly, input bit noisy);
        logic [31:0] la;
        int k;
        la = {addr[31:5], 5'b0};
        @(negedge clk);
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        #1;
        total++;
        if (bmem_read !== 1'b0) begin
            bad++; $display("FAIL %s idle_read: bmem_read=%b required 0", name, bmem_read);
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            bmem_ready  = (i == rdy_dly);
            bmem_rvalid = noisy && ($urandom_range(0, 1) == 1);
            bmem_raddr  = la;
            bmem_rdata  = {$urandom, $urandom};
            #1;
            total++;
            if (bmem_read !== 1'b1 || bmem_addr !== la) begin
                bad++; $display("FAIL %s rd_req: read=%b addr=%h required read=1 addr=%h", name, bmem_read, bmem_addr, la);
            end
        end
        k = 0;
        while (k < 4) begin
            @(negedge clk);
            bmem_ready  = 1'($urandom_range(0, 1));
            dfp_addr    = $urandom;
            bmem_rvalid = 1'b1;
            bmem_raddr  = {la[31:5], 5'($urandom_range(0, 31))};
            bmem_rdata  = line[64*k +: 64];
            if (noisy && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) bmem_rvalid = 1'b0;
                else bmem_raddr = la ^ 32'h0000_0020;
                bmem_rdata = {$urandom, $urandom};
            end else begin
                k++;
            end
            #1;
            total++;
            if (bmem_read !== 1'b0 || dfp_resp !== 1'b0) begin
                bad++; $display("FAIL %s rd_wait: read=%b resp=%b required 0 0", name, bmem_read, dfp_resp);
            end
        end
        @(negedge clk);
        bmem_rvalid = 1'b0; bmem_ready = 1'b0;
        #1;
        total++;
        if (dfp_resp !== 1'b1) begin
            bad++; $display("FAIL %s resp: dfp_resp=%b required 1", name, dfp_resp);
        end
        total++;
        if (dfp_rdata !== line) begin
            bad++; $display("FAIL %s rdata: got %h required %h", name, dfp_rdata, line);
        end
        @(negedge clk);
        dfp_read = 1'b0;
        #1;
        total++;
        if (dfp_resp !== 1'b0 || dfp_rdata !== line || bmem_read !== 1'b0) begin
            bad++; $display("FAIL %s post_read: resp=%b read=%b rdata=%h required 0 0 %h",
                            name, dfp_resp, bmem_read, dfp_rdata, line);
        end
        $display("read  %s addr=%h line=%h", name, addr, line);
    endtask

    task automatic run_write(input string name, input logic [31:0] addr, input logic [255:0] wd,
                             input int rdy_dly, input bit with_read, input bit linger);
        logic [31:0] la;
        la = {addr[31:5], 5'b0};
        @(negedge clk);
        dfp_addr = addr; dfp_wdata = wd; dfp_write = 1'b1; dfp_read = with_read;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        #1;
        total++;
        if (bmem_write !== 1'b0 || bmem_read !== 1'b0) begin
            bad++; $display("FAIL %s idle_write: write=%b read=%b required 0 0", name, bmem_write, bmem_read);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            bmem_ready = 1'b0;
            #1;
            total++;
            if (bmem_write !== 1'b0 || bmem_read !== 1'b0) begin
                bad++; $display("FAIL %s wr_stall: write=%b read=%b required 0 0", name, bmem_write, bmem_read);
            end
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            bmem_ready = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dfp_wdata  = rand256();
            dfp_addr   = $urandom;
            #1;
            total++;
            if (bmem_write !== 1'b1 || bmem_addr !== la || bmem_wdata !== wd[64*b +: 64] || bmem_read !== 1'b0) begin
                bad++; $display("FAIL %s beat%0d: write=%b addr=%h data=%h read=%b required 1 %h %h 0",
                                name, b, bmem_write, bmem_addr, bmem_wdata, bmem_read, la, wd[64*b +: 64]);
            end
        end
        @(negedge clk);
        bmem_ready = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (dfp_resp !== 1'b1 || bmem_write !== 1'b0 || bmem_read !== 1'b0 || bmem_addr !== 32'd0) begin
            bad++; $display("FAIL %s wr_resp: resp=%b write=%b read=%b addr=%h required 1 0 0 0",
                            name, dfp_resp, bmem_write, bmem_read, bmem_addr);
        end
        if (linger) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                dfp_write = 1'b0; dfp_read = 1'b0;
                #1;
                total++;
                if (dfp_resp !== 1'b0 || bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
                    bad++; $display("FAIL %s after_write: resp=%b read=%b write=%b required 0 0 0",
                                    name, dfp_resp, bmem_read, bmem_write);
                end
            end
        end
        $display("write %s addr=%h data=%h", name, addr, wd);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dfp_addr = 32'd0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = 32'd0; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
        @(negedge clk);
        dfp_read = 1'b1; dfp_write = 1'b1; bmem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({dfp_resp, bmem_read, bmem_write} !== 3'b000 || bmem_addr !== 32'd0 ||
            bmem_wdata !== 64'd0 || dfp_rdata !== 256'd0) begin
            bad++; $display("FAIL reset: resp=%b read=%b write=%b addr=%h wdata=%h rdata=%h required all 0",
                            dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata);
        end
        dfp_read = 1'b0; dfp_write = 1'b0; bmem_ready = 1'b0;
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_read_basic;
        run_read("basic_rd", 32'h1000_0044,
                 {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 0, 1'b0);
    endtask

    task automatic test_write_stall;
        run_write("stall_wr", 32'h0000_2020,
                  {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}}, 3, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_write("b2b_wr", 32'h0000_4060, rand256(), 1, 1'b0, 1'b0);
        run_read("b2b_rd", 32'h0000_8000, rand256(), 1, 1'b0);
    endtask

    task automatic test_simultaneous;
        run_write("both_wr", 32'h2222_00A0, rand256(), 2, 1'b1, 1'b1);
    endtask

    task automatic test_mismatch;
        for (int i = 0; i < 3; i++) run_read("mismatch_rd", $urandom, rand256(), i, 1'b1);
    endtask

    task automatic test_reset_midburst;
        logic [31:0]  la;
        logic [255:0] line;
        la   = 32'h3000_0080;
        line = rand256();
        @(negedge clk);
        dfp_addr = la; dfp_read = 1'b1; dfp_write = 1'b0; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
        @(negedge clk);
        bmem_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1; bmem_raddr = la; bmem_rdata = line[64*b +: 64];
        end
        @(negedge clk);
        bmem_rvalid = 1'b0; dfp_read = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({dfp_resp, bmem_read, bmem_write} !== 3'b000 || bmem_addr !== 32'd0 ||
            bmem_wdata !== 64'd0 || dfp_rdata !== 256'd0) begin
            bad++; $display("FAIL async_reset: resp=%b read=%b write=%b addr=%h rdata=%h required all 0",
                            dfp_resp, bmem_read, bmem_write, bmem_addr, dfp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int b = 2; b < 4; b++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1; bmem_raddr = la; bmem_rdata = line[64*b +: 64];
            #1;
            total++;
            if (dfp_resp !== 1'b0 || bmem_read !== 1'b0) begin
                bad++; $display("FAIL stray_beat: resp=%b read=%b required 0 0", dfp_resp, bmem_read);
            end
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        $display("reset mid-burst addr=%h", la);
        run_read("fresh_rd", la, rand256(), 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_read("rand_rd", $urandom, rand256(), $urandom_range(0, 3), 1'b1);
            else
                run_write("rand_wr", $urandom, rand256(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_write_stall;
        test_back_to_back;
        test_simultaneous;
        test_mismatch;
        test_reset_midburst;
        test_random;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
